// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: EX_MEM latch controls and operands flowing into the
// memory stage, plus the registered writeback results and the raw RAM read
// data coming back out. The master side is whoever drives the EX_MEM latch;
// the slave side is the memory stage itself.
interface mem_wb_stage_if #(
    parameter int DW = 32
);
    logic          MEM_load_instr;
    logic          MEM_RF_enable;
    logic          MEM_Size_enable;
    logic          MEM_RW_enable;
    logic          MEM_Enable_signal;
    logic [DW-1:0] MEM_alu_result;
    logic [DW-1:0] MEM_store_data;
    logic [3:0]    MEM_rd;

    logic          WB_RF_enable;
    logic [3:0]    WB_rd;
    logic [DW-1:0] WB_data;
    logic [DW-1:0] DO;

    modport master (
        output MEM_load_instr,
        output MEM_RF_enable,
        output MEM_Size_enable,
        output MEM_RW_enable,
        output MEM_Enable_signal,
        output MEM_alu_result,
        output MEM_store_data,
        output MEM_rd,
        input  WB_RF_enable,
        input  WB_rd,
        input  WB_data,
        input  DO
    );

    modport slave (
        input  MEM_load_instr,
        input  MEM_RF_enable,
        input  MEM_Size_enable,
        input  MEM_RW_enable,
        input  MEM_Enable_signal,
        input  MEM_alu_result,
        input  MEM_store_data,
        input  MEM_rd,
        output WB_RF_enable,
        output WB_rd,
        output WB_data,
        output DO
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage of the 5-stage pipeline.
// Holds a byte-addressable, big-endian data RAM (2**AW bytes), performs the
// load/store for the instruction currently in MEM, and registers the chosen
// writeback value (load data or ALU result) into the MEM/WB latch.
// Word accesses are silently aligned down to a 4-byte boundary, so a word
// never straddles the top of the RAM.
module mem_wb_stage #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  R,
    mem_wb_stage_if.slave         bus
);
    localparam int DEPTH = 2 ** AW;

    // Data RAM; not reset, so a bench may preload it hierarchically.
    logic [7:0]    Mem [DEPTH];

    logic [AW-1:0] addr;
    logic [AW-1:0] addr_b0;
    logic [AW-1:0] addr_b1;
    logic [AW-1:0] addr_b2;
    logic [AW-1:0] addr_b3;
    logic          ram_write;
    logic [DW-1:0] read_data;
    logic [DW-1:0] wb_next;

    // Byte lane addresses: word accesses force the low two bits to 00 and
    // walk MSB-first through the four bytes; byte accesses use lane 0 only.
    always_comb begin
        addr    = bus.MEM_alu_result[AW-1:0];
        addr_b0 = addr;
        addr_b1 = {addr[AW-1:2], 2'b01};
        addr_b2 = {addr[AW-1:2], 2'b10};
        addr_b3 = {addr[AW-1:2], 2'b11};
        if (bus.MEM_Size_enable) begin
            addr_b0 = {addr[AW-1:2], 2'b00};
        end
    end

    // Combinational read port: shows current (pre-write) RAM contents
    // whenever the RAM is enabled, zero otherwise.
    always_comb begin
        read_data = '0;
        if (bus.MEM_Enable_signal) begin
            if (bus.MEM_Size_enable) begin
                read_data = {Mem[addr_b0], Mem[addr_b1], Mem[addr_b2], Mem[addr_b3]};
            end else begin
                read_data = {{(DW-8){1'b0}}, Mem[addr_b0]};
            end
        end
    end

    // Writeback select and RAM write strobe for this cycle.
    always_comb begin
        ram_write = bus.MEM_Enable_signal & bus.MEM_RW_enable;
        wb_next   = bus.MEM_load_instr ? read_data : bus.MEM_alu_result;
    end

    assign bus.DO = read_data;

    // MEM/WB latch plus RAM write; a low reset at the edge also blocks the
    // store, so an access interrupted by reset never reaches the RAM.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            bus.WB_RF_enable <= 1'b0;
            bus.WB_rd        <= '0;
            bus.WB_data      <= '0;
        end else begin
            bus.WB_RF_enable <= bus.MEM_RF_enable;
            bus.WB_rd        <= bus.MEM_rd;
            bus.WB_data      <= wb_next;
            if (ram_write) begin
                if (bus.MEM_Size_enable) begin
                    Mem[addr_b0] <= bus.MEM_store_data[31:24];
                    Mem[addr_b1] <= bus.MEM_store_data[23:16];
                    Mem[addr_b2] <= bus.MEM_store_data[15:8];
                    Mem[addr_b3] <= bus.MEM_store_data[7:0];
                end else begin
                    Mem[addr_b0] <= bus.MEM_store_data[7:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases for reset, word/byte
// stores and loads, alignment, ALU path, bubbles and async reset, then a
// randomized run compared against a byte-array model of the data RAM.
module tb_mem_wb_stage;
    logic clk;
    logic R;
    int   checks;
    int   errors;
    logic [7:0]  ref_mem [256];
    logic [31:0] last_do;

    mem_wb_stage_if #(.DW(32)) bus ();

    mem_wb_stage #(.AW(8), .DW(32)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference read: big-endian word at the aligned-down address, or a
    // zero-extended byte; nothing when the RAM is not enabled.
    function automatic logic [31:0] modelRead(input logic en, input logic size, input logic [31:0] alu);
        int a;
        a = int'(alu & 32'hFF);
        if (!en) return 32'h0;
        if (size) begin
            a = a - (a % 4);
            return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        end
        return {24'h0, ref_mem[a]};
    endfunction

    task automatic modelWrite(input logic size, input logic [31:0] alu, input logic [31:0] sd);
        int a;
        a = int'(alu & 32'hFF);
        if (size) begin
            a = a - (a % 4);
            ref_mem[a]   = sd[31:24];
            ref_mem[a+1] = sd[23:16];
            ref_mem[a+2] = sd[15:8];
            ref_mem[a+3] = sd[7:0];
        end else begin
            ref_mem[a] = sd[7:0];
        end
    endtask

    task automatic driveBus(input logic load, input logic rf, input logic size, input logic rw,
                            input logic en, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [3:0] rd);
        bus.MEM_load_instr    = load;
        bus.MEM_RF_enable     = rf;
        bus.MEM_Size_enable   = size;
        bus.MEM_RW_enable     = rw;
        bus.MEM_Enable_signal = en;
        bus.MEM_alu_result    = alu;
        bus.MEM_store_data    = sd;
        bus.MEM_rd            = rd;
    endtask

    // One pipeline cycle: drive on the falling edge, check DO, clock it in,
    // then check the MEM/WB latch and update the RAM model.
    task automatic applyStimulus(input logic load, input logic rf, input logic size, input logic rw,
                                 input logic en, input logic [31:0] alu, input logic [31:0] sd,
                                 input logic [3:0] rd, input bit check_do);
        logic [31:0] exp_do;
        logic [31:0] exp_data;
        @(negedge clk);
        driveBus(load, rf, size, rw, en, alu, sd, rd);
        exp_do = modelRead(en, size, alu);
        #1;
        last_do = bus.DO;
        if (check_do) checkOutput("DO", bus.DO, exp_do);
        exp_data = load ? exp_do : alu;
        @(posedge clk);
        if (en && rw) modelWrite(size, alu, sd);
        #1;
        if (check_do) checkOutput("WB_data", bus.WB_data, exp_data);
        checkOutput("WB_RF_enable", {31'b0, bus.WB_RF_enable}, {31'b0, rf});
        checkOutput("WB_rd", {28'b0, bus.WB_rd}, {28'b0, rd});
    endtask

    function automatic int ramDiffs();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.Mem[i] !== ref_mem[i]) n++;
        end
        return n;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        last_do = 32'h0;
        R = 1'b0;
        driveBus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd7);

        // Reset holds the latch clear even with RF_enable requested.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_WB_RF_enable", {31'b0, bus.WB_RF_enable}, 32'h0);
        checkOutput("rst_WB_rd", {28'b0, bus.WB_rd}, 32'h0);
        checkOutput("rst_WB_data", bus.WB_data, 32'h0);
        @(negedge clk);
        R = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_WB_RF_enable", {31'b0, bus.WB_RF_enable}, 32'h1);
        checkOutput("post_rst_WB_rd", {28'b0, bus.WB_rd}, 32'h7);
        checkOutput("post_rst_WB_data", bus.WB_data, 32'h55);

        // Fill RAM with known random words (pre-fill contents are unknown).
        for (int w = 0; w < 64; w++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'(w * 4), $urandom, 4'd0, 1'b0);
        end
        checkOutput("fill_ram_diffs", 32'(ramDiffs()), 32'h0);

        // Word store then load.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'd0, 1'b1);
        checkOutput("Mem8", {24'b0, dut.Mem[8]}, 32'hDE);
        checkOutput("Mem9", {24'b0, dut.Mem[9]}, 32'hAD);
        checkOutput("Mem10", {24'b0, dut.Mem[10]}, 32'hBE);
        checkOutput("Mem11", {24'b0, dut.Mem[11]}, 32'hEF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 4'd3, 1'b1);
        checkOutput("word_load_data", bus.WB_data, 32'hDEAD_BEEF);
        checkOutput("word_load_rd", {28'b0, bus.WB_rd}, 32'h3);

        // Byte store touches one byte only; byte and word loads see it.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000D, 32'h1234_56A5, 4'd0, 1'b1);
        checkOutput("MemD", {24'b0, dut.Mem[13]}, 32'hA5);
        checkOutput("byte_store_ram_diffs", 32'(ramDiffs()), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000D, 32'h0, 4'd4, 1'b1);
        checkOutput("byte_load_data", bus.WB_data, 32'h0000_00A5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h0, 4'd5, 1'b1);
        checkOutput("word_0C_byte1", {24'b0, last_do[23:16]}, 32'hA5);

        // Misaligned word accesses align down.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000B, 32'h0, 4'd6, 1'b1);
        checkOutput("misaligned_load", bus.WB_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 32'hCAFE_F00D, 4'd0, 1'b1);
        checkOutput("MemFC", {24'b0, dut.Mem[252]}, 32'hCA);
        checkOutput("MemFF", {24'b0, dut.Mem[255]}, 32'h0D);
        checkOutput("top_store_ram_diffs", 32'(ramDiffs()), 32'h0);

        // ALU path and bubble.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 4'd2, 1'b1);
        checkOutput("alu_path_data", bus.WB_data, 32'h42);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'd0, 1'b1);
        checkOutput("bubble_ram_diffs", 32'(ramDiffs()), 32'h0);

        // Randomized mix, including illegal load+store and bubbles.
        for (int n = 0; n < 400; n++) begin
            logic en;
            logic rw;
            logic load;
            en   = ($urandom_range(0, 7) != 0);
            rw   = ($urandom_range(0, 2) == 0);
            load = rw ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(load, 1'($urandom), 1'($urandom), rw, en,
                          $urandom, $urandom, 4'($urandom), 1'b1);
        end
        checkOutput("random_ram_diffs", 32'(ramDiffs()), 32'h0);

        // Async reset during a word store: latch clears without a clock and
        // the store never lands.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 4'd9, 1'b1);
        @(negedge clk);
        driveBus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'd1);
        #2;
        R = 1'b0;
        #1;
        checkOutput("async_WB_RF_enable", {31'b0, bus.WB_RF_enable}, 32'h0);
        checkOutput("async_WB_rd", {28'b0, bus.WB_rd}, 32'h0);
        checkOutput("async_WB_data", bus.WB_data, 32'h0);
        @(posedge clk);
        #1;
        for (int k = 32; k < 36; k++) begin
            checkOutput("async_store_blocked", {24'b0, dut.Mem[k]}, {24'b0, ref_mem[k]});
        end
        @(negedge clk);
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        R = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'd8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
